// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: op encodings, FSM states, defaults.
package div_issue_ctrl_pkg;

   localparam int unsigned XLEN_DEF = 32;

   // bit1 = unsigned, bit0 = remainder
   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_MOD  = 2'b01;
   localparam logic [1:0] DIV_OP_DIVU = 2'b10;
   localparam logic [1:0] DIV_OP_MODU = 2'b11;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DRAIN = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   function automatic logic op_is_signed(input logic [1:0] op);
      return !op[1];
   endfunction

   function automatic logic op_is_mod(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Upstream op handshake, divider port and downstream result handshake for div_issue_ctrl.
interface div_issue_ctrl_if
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_op;
   logic [XLEN-1:0] in_src1;
   logic [XLEN-1:0] in_src2;

   logic            div_start;
   logic            div_signed;
   logic [XLEN-1:0] div_dividend;
   logic [XLEN-1:0] div_divisor;
   logic            div_busy;
   logic            div_done;
   logic            div_dz;
   logic [XLEN-1:0] div_quotient;
   logic [XLEN-1:0] div_remainder;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_dz;

   // Controller side
   modport slave (
      input  flush, in_valid, in_op, in_src1, in_src2,
      output in_ready,
      output div_start, div_signed, div_dividend, div_divisor,
      input  div_busy, div_done, div_dz, div_quotient, div_remainder,
      output out_valid, out_result, out_dz,
      input  out_ready
   );

   // Pipeline / divider side
   modport master (
      output flush, in_valid, in_op, in_src1, in_src2,
      input  in_ready,
      input  div_start, div_signed, div_dividend, div_divisor,
      output div_busy, div_done, div_dz, div_quotient, div_remainder,
      input  out_valid, out_result, out_dz,
      output out_ready
   );

endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage initiator for the multi-cycle divider: issues one op, waits, holds the result
// until accepted, and drains an in-flight division after a flush.
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            resetn,
   div_issue_ctrl_if.slave bus
);

   logic [2:0]      state_q, state_d;
   logic            signed_q;
   logic            mod_q;
   logic [XLEN-1:0] src1_q;
   logic [XLEN-1:0] src2_q;
   logic [XLEN-1:0] result_q;
   logic            dz_q;

   logic            accept;
   logic            load_res;

   // The divider cannot be aborted, so busy is never consulted: DRAIN simply waits for done.
   logic            unused_busy;
   assign unused_busy = bus.div_busy;

   assign bus.in_ready = !bus.flush &&
                         ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready));
   assign accept       = bus.in_valid && bus.in_ready;
   assign load_res     = (state_q == ST_WAIT) && bus.div_done && !bus.flush;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_ISSUE;
         ST_ISSUE: state_d = bus.flush ? ST_IDLE : ST_WAIT;
         ST_WAIT: begin
            if (bus.div_done)   state_d = bus.flush ? ST_IDLE : ST_HOLD;
            else if (bus.flush) state_d = ST_DRAIN;
         end
         ST_HOLD: begin
            if (bus.flush)          state_d = ST_IDLE;
            else if (bus.out_ready) state_d = accept ? ST_ISSUE : ST_IDLE;
         end
         ST_DRAIN: if (bus.div_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         signed_q <= 1'b0;
         mod_q    <= 1'b0;
         src1_q   <= '0;
         src2_q   <= '0;
         result_q <= '0;
         dz_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            signed_q <= op_is_signed(bus.in_op);
            mod_q    <= op_is_mod(bus.in_op);
            src1_q   <= bus.in_src1;
            src2_q   <= bus.in_src2;
         end
         if (load_res) begin
            result_q <= mod_q ? bus.div_remainder : bus.div_quotient;
            dz_q     <= bus.div_dz;
         end
      end
   end

   // A flush in ISSUE suppresses the start so nothing needs draining.
   assign bus.div_start    = (state_q == ST_ISSUE) && !bus.flush;
   assign bus.div_signed   = signed_q;
   assign bus.div_dividend = src1_q;
   assign bus.div_divisor  = src2_q;
   assign bus.out_valid    = (state_q == ST_HOLD);
   assign bus.out_result   = result_q;
   assign bus.out_dz       = dz_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed self-checking bench for div_issue_ctrl with a behavioural XLEN-cycle divider.
module tb_div_issue_ctrl;
   import div_issue_ctrl_pkg::*;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   div_issue_ctrl_if #(.XLEN(XLEN)) bus ();

   div_issue_ctrl #(.XLEN(XLEN)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Divider model: zero divisor completes the cycle after start, otherwise XLEN cycles later.
   int unsigned     dcnt;
   logic            m_sgn;
   logic [XLEN-1:0] m_a, m_b;

   function automatic logic [XLEN-1:0] mdl_quo(input logic s, input logic [XLEN-1:0] a, b);
      if (s) return $signed(a) / $signed(b);
      return a / b;
   endfunction

   function automatic logic [XLEN-1:0] mdl_rem(input logic s, input logic [XLEN-1:0] a, b);
      if (s) return $signed(a) % $signed(b);
      return a % b;
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.div_busy      <= 1'b0;
         bus.div_done      <= 1'b0;
         bus.div_dz        <= 1'b0;
         bus.div_quotient  <= '0;
         bus.div_remainder <= '0;
         dcnt              <= 0;
      end else begin
         bus.div_done <= 1'b0;
         if (bus.div_start) begin
            m_sgn <= bus.div_signed;
            m_a   <= bus.div_dividend;
            m_b   <= bus.div_divisor;
            if (bus.div_divisor == '0) begin
               bus.div_done      <= 1'b1;
               bus.div_dz        <= 1'b1;
               bus.div_quotient  <= '0;
               bus.div_remainder <= bus.div_dividend;
            end else begin
               bus.div_busy <= 1'b1;
               bus.div_dz   <= 1'b0;
               dcnt         <= XLEN;
            end
         end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
         end else if (dcnt == 1) begin
            dcnt              <= 0;
            bus.div_busy      <= 1'b0;
            bus.div_done      <= 1'b1;
            bus.div_quotient  <= mdl_quo(m_sgn, m_a, m_b);
            bus.div_remainder <= mdl_rem(m_sgn, m_a, m_b);
         end
      end
   end

   always @(posedge clk) begin
      if (resetn && bus.div_start) assert (!bus.div_busy);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents an op and returns one cycle after the accepting edge (cycle T+1).
   task automatic accept_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_src1  = a;
      bus.in_src2  = b;
      for (int i = 0; i < 100 && !bus.in_ready; i++) tick();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!bus.out_valid && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #1;
      checks += 7;
      if (bus.in_ready !== 1'b1)    begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
      if (bus.out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
      if (bus.div_start !== 1'b0)   begin errors++; $display("FAIL rst_div_start: got %b want 0", bus.div_start); end
      if (bus.div_signed !== 1'b0)  begin errors++; $display("FAIL rst_div_signed: got %b want 0", bus.div_signed); end
      if (bus.div_dividend !== '0)  begin errors++; $display("FAIL rst_dividend: got %h want 0", bus.div_dividend); end
      if (bus.out_result !== '0)    begin errors++; $display("FAIL rst_out_result: got %h want 0", bus.out_result); end
      if (bus.out_dz !== 1'b0)      begin errors++; $display("FAIL rst_out_dz: got %b want 0", bus.out_dz); end
      tick();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_div_signed();
      int n;
      accept_op(DIV_OP_DIV, 32'hFFFF_FFF9, 32'h2);
      checks += 4;
      if (bus.div_start !== 1'b1)             begin errors++; $display("FAIL divw_start: got %b want 1", bus.div_start); end
      if (bus.div_signed !== 1'b1)            begin errors++; $display("FAIL divw_signed: got %b want 1", bus.div_signed); end
      if (bus.div_dividend !== 32'hFFFF_FFF9) begin errors++; $display("FAIL divw_dividend: got %h want fffffff9", bus.div_dividend); end
      if (bus.in_ready !== 1'b0)              begin errors++; $display("FAIL divw_in_ready: got %b want 0", bus.in_ready); end
      wait_out(n);
      checks += 3;
      if (n != 34)                          begin errors++; $display("FAIL divw_latency: got %0d want 34", n); end
      if (bus.out_result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL divw_result: got %h want fffffffd", bus.out_result); end
      if (bus.out_dz !== 1'b0)              begin errors++; $display("FAIL divw_dz: got %b want 0", bus.out_dz); end
      consume();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL divw_release: out_valid=%b want 0", bus.out_valid); end
   endtask

   task automatic test_mod();
      int n;
      accept_op(DIV_OP_MODU, 32'hFFFF_FFF9, 32'h2);
      checks++;
      if (bus.div_signed !== 1'b0) begin errors++; $display("FAIL modwu_signed: got %b want 0", bus.div_signed); end
      wait_out(n);
      checks += 2;
      if (n != 34)                          begin errors++; $display("FAIL modwu_latency: got %0d want 34", n); end
      if (bus.out_result !== 32'h0000_0001) begin errors++; $display("FAIL modwu_result: got %h want 00000001", bus.out_result); end
      consume();
      accept_op(DIV_OP_MOD, 32'hFFFF_FFF9, 32'h2);
      wait_out(n);
      checks += 2;
      if (n != 34)                          begin errors++; $display("FAIL modw_latency: got %0d want 34", n); end
      if (bus.out_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL modw_result: got %h want ffffffff", bus.out_result); end
      consume();
   endtask

   task automatic test_div_zero();
      int n;
      accept_op(DIV_OP_DIV, 32'h5, 32'h0);
      wait_out(n);
      checks += 3;
      if (n != 2)                  begin errors++; $display("FAIL dz_div_latency: got %0d want 2", n); end
      if (bus.out_result !== '0)   begin errors++; $display("FAIL dz_div_result: got %h want 0", bus.out_result); end
      if (bus.out_dz !== 1'b1)     begin errors++; $display("FAIL dz_div_flag: got %b want 1", bus.out_dz); end
      consume();
      accept_op(DIV_OP_MOD, 32'h5, 32'h0);
      wait_out(n);
      checks += 3;
      if (n != 2)                       begin errors++; $display("FAIL dz_mod_latency: got %0d want 2", n); end
      if (bus.out_result !== 32'h5)     begin errors++; $display("FAIL dz_mod_result: got %h want 5", bus.out_result); end
      if (bus.out_dz !== 1'b1)          begin errors++; $display("FAIL dz_mod_flag: got %b want 1", bus.out_dz); end
      consume();
   endtask

   task automatic test_flush();
      int n;
      int seen_valid;
      accept_op(DIV_OP_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 9; i++) tick();
      bus.flush = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
      tick();
      bus.flush = 1'b0;
      #1;
      n = 0;
      seen_valid = 0;
      while (!bus.in_ready && n < 60) begin
         if (bus.out_valid) seen_valid++;
         tick();
         n++;
      end
      checks += 3;
      if (n != 24)               begin errors++; $display("FAIL flush_drain_len: got %0d want 24", n); end
      if (seen_valid != 0)       begin errors++; $display("FAIL flush_out_valid: got %0d cycles want 0", seen_valid); end
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid: got %b want 0", bus.out_valid); end
      accept_op(DIV_OP_DIVU, 32'd100, 32'd7);
      wait_out(n);
      checks += 2;
      if (n != 34)                begin errors++; $display("FAIL flush_next_latency: got %0d want 34", n); end
      if (bus.out_result !== 32'd14) begin errors++; $display("FAIL flush_next_result: got %0d want 14", bus.out_result); end
      consume();
   endtask

   task automatic test_back_to_back();
      int n;
      int bad;
      accept_op(DIV_OP_DIV, 32'd100, 32'd7);
      wait_out(n);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd14 || bus.in_ready !== 1'b0) bad++;
      end
      checks += 2;
      if (n != 34) begin errors++; $display("FAIL b2b_first_latency: got %0d want 34", n); end
      if (bad != 0) begin errors++; $display("FAIL b2b_hold_stable: got %0d bad cycles want 0", bad); end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_op     = DIV_OP_MOD;
      bus.in_src1   = 32'hFFFF_FF9C;
      bus.in_src2   = 32'd7;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
      tick();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks += 3;
      if (bus.div_start !== 1'b1)             begin errors++; $display("FAIL b2b_start: got %b want 1", bus.div_start); end
      if (bus.out_valid !== 1'b0)             begin errors++; $display("FAIL b2b_valid_drop: got %b want 0", bus.out_valid); end
      if (bus.div_dividend !== 32'hFFFF_FF9C) begin errors++; $display("FAIL b2b_dividend: got %h want ffffff9c", bus.div_dividend); end
      wait_out(n);
      checks += 2;
      if (n != 34)                          begin errors++; $display("FAIL b2b_second_latency: got %0d want 34", n); end
      if (bus.out_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_second_result: got %h want fffffffe", bus.out_result); end
   endtask

   task automatic test_reset_mid();
      int n;
      consume();
      accept_op(DIV_OP_DIV, 32'd5, 32'd2);
      for (int i = 0; i < 10; i++) tick();
      resetn = 1'b0;
      #1;
      checks += 5;
      if (bus.out_valid !== 1'b0)     begin errors++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
      if (bus.in_ready !== 1'b1)      begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
      if (bus.div_dividend !== '0)    begin errors++; $display("FAIL rstmid_dividend: got %h want 0", bus.div_dividend); end
      if (bus.div_divisor !== '0)     begin errors++; $display("FAIL rstmid_divisor: got %h want 0", bus.div_divisor); end
      if (bus.out_result !== '0)      begin errors++; $display("FAIL rstmid_result: got %h want 0", bus.out_result); end
      tick();
      tick();
      resetn = 1'b1;
      tick();
      accept_op(DIV_OP_DIV, 32'd5, 32'd2);
      wait_out(n);
      checks += 2;
      if (n != 34)                 begin errors++; $display("FAIL rstmid_latency: got %0d want 34", n); end
      if (bus.out_result !== 32'd2) begin errors++; $display("FAIL rstmid_result2: got %0d want 2", bus.out_result); end
      consume();
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = 2'b00;
      bus.in_src1   = '0;
      bus.in_src2   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_div_signed();
      test_mod();
      test_div_zero();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
